// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  // Width of the wait-state counter; it only ever holds MEM_LAT-1.
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner pick between fetch and load/store requesters, DM favoured with an anti-starvation streak.
// Latency: winner is combinational; streak updates on the accepting edge.
// Backpressure: losers simply stay pending; selection is only consumed when arb_en_i is high.
module mem_arb_select
  import riscv_mem_pkg::*;
#(
  parameter int MAX_DATA_BURST = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic win_vld_o,
  output logic win_id_o
);

  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_BURST);

  logic [SW-1:0] streak_q;

  // DM wins a collision unless IF has already been passed over MAX_DATA_BURST times.
  always_comb begin
    win_vld_o = if_req_i | dm_req_i;
    win_id_o  = REQ_DM;
    if (if_req_i && (!dm_req_i || (streak_q == STREAK_MAX))) begin
      win_id_o = REQ_IF;
    end
  end

  // Count DM grants that bypassed a waiting IF; any other grant clears the streak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak_q <= '0;
    end else if (arb_en_i && win_vld_o) begin
      if ((win_id_o == REQ_IF) || !if_req_i) begin
        streak_q <= '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_q <= streak_q + SW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (DM) requesters.
// Latency: request sampled at E, gnt at E+1, rvalid at E+1+MEM_LAT; one transaction per MEM_LAT+1 cycles.
// Backpressure: requesters hold req and payload until gnt; requests seen during WAIT wait for the next arbitration edge.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MEM_LAT        = 2,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = cnt_width(MEM_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          id_q;
  logic          we_q;

  logic arb_en;
  logic win_vld;
  logic win_id;

  // Arbitration happens from IDLE and from DONE, never while a transaction is counting.
  assign arb_en = (state_q != ST_WAIT);
  assign busy   = (state_q != ST_IDLE);

  mem_arb_select #(
    .MAX_DATA_BURST(MAX_DATA_BURST)
  ) u_sel (
    .clk      (clk),
    .reset    (reset),
    .arb_en_i (arb_en),
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .win_vld_o(win_vld),
    .win_id_o (win_id)
  );

  // Transaction FSM: accept winner, count fixed memory latency, return data with a one-cycle rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      id_q      <= REQ_IF;
      we_q      <= 1'b0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      // Strobes are single-cycle pulses unless re-asserted below.
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            if (id_q == REQ_DM) begin
              dm_rvalid <= 1'b1;
              if (!we_q) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          // IDLE and DONE (and any stray encoding) arbitrate on this edge.
          if (win_vld) begin
            state_q <= ST_WAIT;
            cnt_q   <= CNT_LOAD;
            id_q    <= win_id;
            mem_en  <= 1'b1;
            if (win_id == REQ_DM) begin
              we_q      <= dm_we;
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              dm_gnt    <= 1'b1;
            end else begin
              we_q     <= 1'b0;
              mem_addr <= if_addr;
              if_gnt   <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, MAX_DATA_BURST=4.
// Latency: checks gnt at E+1 and rvalid at E+3 relative to the sampling edge.
// Backpressure: requesters hold req/payload until gnt; a hold violation is reported.
module tb_mem_port_arbiter;

  localparam logic [31:0] BAD = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = BAD;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Previous-cycle request state for the hold-until-gnt rule.
  logic        p_rst = 1'b1;
  logic        p_if_req = 1'b0;
  logic [31:0] p_if_addr = '0;
  logic        p_dm_req = 1'b0;
  logic        p_dm_we = 1'b0;
  logic [31:0] p_dm_addr = '0;
  logic [31:0] p_dm_wdata = '0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_DATA_BURST(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Ends the current cycle: enforces the request hold rule, then advances to 1ns after the next edge.
  task automatic tick();
    if (!reset && !p_rst) begin
      if (p_if_req && !if_gnt && (!if_req || (if_addr !== p_if_addr))) begin
        errors++;
        $display("FAIL protocol_if: req=%0b addr=%h, required held req with addr=%h", if_req, if_addr, p_if_addr);
      end
      if (p_dm_req && !dm_gnt &&
          (!dm_req || ({dm_we, dm_addr, dm_wdata} !== {p_dm_we, p_dm_addr, p_dm_wdata}))) begin
        errors++;
        $display("FAIL protocol_dm: req=%0b payload changed before gnt", dm_req);
      end
    end
    p_rst      = reset;
    p_if_req   = if_req;
    p_if_addr  = if_addr;
    p_dm_req   = dm_req;
    p_dm_we    = dm_we;
    p_dm_addr  = dm_addr;
    p_dm_wdata = dm_wdata;
    @(posedge clk);
    #1;
  endtask

  // One complete IF read; cycle numbers are relative to the sampling edge E0.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] word,
                           input logic [31:0] dm_rd_exp, input string tag);
    logic dm_odd;
    dm_odd  = 1'b0;
    if_req  = 1'b1;
    if_addr = addr;
    tick();  // cycle 1
    dm_odd |= dm_gnt | dm_rvalid | (dm_rdata !== dm_rd_exp);
    checks++;
    if ({mem_en, mem_we, if_gnt, busy} !== 4'b1011) begin
      errors++;
      $display("FAIL %s_c1_ctrl: en/we/gnt/busy=%b, required 1011", tag, {mem_en, mem_we, if_gnt, busy});
    end
    checks++;
    if (mem_addr !== addr) begin
      errors++;
      $display("FAIL %s_c1_addr: got %h, required %h", tag, mem_addr, addr);
    end
    if_req = 1'b0;
    tick();  // cycle 2
    dm_odd |= dm_gnt | dm_rvalid | (dm_rdata !== dm_rd_exp);
    mem_rdata = word;
    checks++;
    if ({mem_en, if_gnt, if_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL %s_c2_ctrl: en/gnt/rvalid=%b, required 000", tag, {mem_en, if_gnt, if_rvalid});
    end
    tick();  // cycle 3
    dm_odd |= dm_gnt | dm_rvalid | (dm_rdata !== dm_rd_exp);
    mem_rdata = BAD;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, word}) begin
      errors++;
      $display("FAIL %s_c3_rdata: rvalid=%0b rdata=%h, required 1 %h", tag, if_rvalid, if_rdata, word);
    end
    tick();  // cycle 4
    dm_odd |= dm_gnt | dm_rvalid | (dm_rdata !== dm_rd_exp);
    checks++;
    if ({if_rvalid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s_c4_idle: rvalid/busy=%b, required 00", tag, {if_rvalid, busy});
    end
    checks++;
    if (dm_odd !== 1'b0) begin
      errors++;
      $display("FAIL %s_dm_quiet: dm side active=%0b, required 0", tag, dm_odd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_en, mem_we,
         mem_addr, mem_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%0b mem_en=%0b mem_addr=%h, required all 0", busy, mem_en, mem_addr);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, mem_en, if_gnt, dm_gnt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: busy/en/ignt/dgnt=%b, required 0000", {busy, mem_en, if_gnt, dm_gnt});
    end
  endtask

  task automatic test_fetch();
    run_fetch(32'h0000_0100, 32'h0050_0093, 32'h0, "fetch");
  endtask

  task automatic test_collision();
    if_req = 1'b1; if_addr = 32'h0000_0108;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0200; dm_wdata = '0;
    tick();  // cycle 1
    checks++;
    if ({dm_gnt, if_gnt, mem_en, mem_we} !== 4'b1010) begin
      errors++;
      $display("FAIL coll_c1_ctrl: dgnt/ignt/en/we=%b, required 1010", {dm_gnt, if_gnt, mem_en, mem_we});
    end
    checks++;
    if (mem_addr !== 32'h0000_0200) begin
      errors++;
      $display("FAIL coll_c1_addr: got %h, required 00000200", mem_addr);
    end
    dm_req = 1'b0;
    tick();  // cycle 2
    mem_rdata = 32'h0000_002A;
    tick();  // cycle 3
    mem_rdata = BAD;
    checks++;
    if ({dm_rvalid, dm_rdata, if_gnt, busy} !== {1'b1, 32'h0000_002A, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL coll_c3_dm: rvalid=%0b rdata=%h ignt=%0b busy=%0b, required 1 0000002a 0 1",
               dm_rvalid, dm_rdata, if_gnt, busy);
    end
    tick();  // cycle 4: IF won from DONE
    checks++;
    if ({if_gnt, dm_rvalid, mem_en} !== 3'b101) begin
      errors++;
      $display("FAIL coll_c4_ifgnt: ignt/drvalid/en=%b, required 101", {if_gnt, dm_rvalid, mem_en});
    end
    checks++;
    if (mem_addr !== 32'h0000_0108) begin
      errors++;
      $display("FAIL coll_c4_addr: got %h, required 00000108", mem_addr);
    end
    if_req = 1'b0;
    tick();  // cycle 5
    mem_rdata = 32'h0000_0013;
    tick();  // cycle 6
    mem_rdata = BAD;
    checks++;
    if ({if_rvalid, if_rdata, dm_rdata} !== {1'b1, 32'h0000_0013, 32'h0000_002A}) begin
      errors++;
      $display("FAIL coll_c6_if: rvalid=%0b if_rdata=%h dm_rdata=%h, required 1 00000013 0000002a",
               if_rvalid, if_rdata, dm_rdata);
    end
    tick();  // cycle 7
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL coll_c7_idle: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_store();
    int en_n, we_n, rv_n;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0204; dm_wdata = 32'hDEAD_BEEF;
    tick();  // cycle 1
    en_n = int'(mem_en); we_n = int'(mem_we); rv_n = int'(dm_rvalid);
    checks++;
    if ({dm_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 32'h0000_0204, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_c1: gnt/en/we=%b addr=%h wdata=%h, required 111 00000204 deadbeef",
               {dm_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      tick();
      en_n += int'(mem_en); we_n += int'(mem_we); rv_n += int'(dm_rvalid);
      if (c == 2) mem_rdata = 32'h5555_5555;  // must not land in dm_rdata
      if (c == 3) begin
        mem_rdata = BAD;
        checks++;
        if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h0000_002A}) begin
          errors++;
          $display("FAIL store_c3: rvalid=%0b rdata=%h, required 1 0000002a", dm_rvalid, dm_rdata);
        end
      end
    end
    checks++;
    if ((en_n != 1) || (we_n != 1) || (rv_n != 1)) begin
      errors++;
      $display("FAIL store_pulses: en=%0d we=%0d rvalid=%0d, required 1 1 1", en_n, we_n, rv_n);
    end
  endtask

  task automatic test_starvation();
    logic [5:0] order;
    logic [2:0] gi;
    int cyc, last;
    logic gap_bad;
    order = '0; gi = '0; cyc = 0; last = 0; gap_bad = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0140;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0240; dm_wdata = '0;
    while ((gi < 3'd6) && (cyc < 40)) begin
      tick();
      cyc++;
      if (if_gnt || dm_gnt) begin
        if ((gi != 3'd0) && (cyc - last != 3)) gap_bad = 1'b1;
        last = cyc;
        order[gi] = if_gnt;
        if (if_gnt) begin
          checks++;
          if (dut.u_sel.streak_q !== 3'd0) begin
            errors++;
            $display("FAIL starve_streak_clr: streak=%0d, required 0", dut.u_sel.streak_q);
          end
        end
        if (dm_gnt && (gi == 3'd3)) begin
          checks++;
          if (dut.u_sel.streak_q !== 3'd4) begin
            errors++;
            $display("FAIL starve_streak_max: streak=%0d, required 4", dut.u_sel.streak_q);
          end
        end
        gi = gi + 3'd1;
      end
    end
    checks++;
    if ((gi !== 3'd6) || (order !== 6'b01_0000)) begin
      errors++;
      $display("FAIL starve_order: grants=%0d order(bit i=IF)=%b, required 6 010000", gi, order);
    end
    checks++;
    if (gap_bad !== 1'b0) begin
      errors++;
      $display("FAIL starve_spacing: grants not 3 cycles apart, required 3");
    end
    dm_req = 1'b0;
    cyc = 0;
    while (!if_gnt && (cyc < 20)) begin
      tick();
      cyc++;
    end
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL starve_if_drain: if_gnt=%0b after %0d cycles, required 1", if_gnt, cyc);
    end
    if_req = 1'b0;
    cyc = 0;
    while (busy && (cyc < 20)) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_async_reset();
    if_req = 1'b1; if_addr = 32'h0000_010C;
    tick();
    if_req = 1'b0;
    tick();
    mem_rdata = 32'h1234_5678;
    tick();  // cycle 3: rvalid with data
    mem_rdata = BAD;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 32'h1234_5678}) begin
      errors++;
      $display("FAIL areset_pre: rvalid=%0b rdata=%h, required 1 12345678", if_rvalid, if_rdata);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, mem_en, mem_we,
         mem_addr, mem_wdata, busy} !== '0) begin
      errors++;
      $display("FAIL areset_now: busy=%0b if_rdata=%h dm_rdata=%h mem_addr=%h, required all 0",
               busy, if_rdata, dm_rdata, mem_addr);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({if_rvalid, busy, mem_en, if_rdata} !== '0) begin
      errors++;
      $display("FAIL areset_after: rvalid=%0b busy=%0b en=%0b rdata=%h, required 0", if_rvalid, busy, mem_en, if_rdata);
    end
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    if_req = 1'b1; if_addr = 32'h0000_0180;
    tick();  // cycle 1
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL rwait_gnt: if_gnt=%0b, required 1", if_gnt);
    end
    if_req = 1'b0;
    tick();  // cycle 2, in WAIT
    mem_rdata = 32'hCAFE_0001;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, if_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL rwait_reset: busy/rvalid=%b, required 00", {busy, if_rvalid});
    end
    tick();
    mem_rdata = BAD;
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      seen |= if_rvalid | busy;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rwait_discard: rvalid/busy seen=%0b, required 0", seen);
    end
    run_fetch(32'h0000_0104, 32'h00A0_0113, 32'h0, "refetch");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_collision();
    test_store();
    test_starvation();
    test_async_reset();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time, required finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch requester (IF) and the load/store requester (DM).
- Sits between Instruction_Fetch/Memory_Access and the memory macro, as a step toward a multi-cycle/pipelined riscv core.
- Runs a req/gnt/rvalid handshake per requester and a wait-state counter for fixed memory latency.
- Uses priority arbitration (DM over IF) with an anti-starvation limit.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from mem_en cycle to the last cycle in which mem_rdata is valid-to-sample (legal range 1..15)
- MAX_DATA_BURST, 4, consecutive DM grants allowed while IF is pending before IF is forced

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: IF request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched word
- dm_req  in  1  data request; held with payload until dm_gnt
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle pulse: DM request accepted
- dm_rvalid  out  1  one-cycle pulse: DM access complete (read data valid, or write done)
- dm_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset (async, any time): state=IDLE, cnt=0, streak=0. All outputs are 0, including rdata registers and mem_* buses. An in-flight transaction is discarded and no rvalid is issued.
- States:
  - IDLE: arbitrate at each edge; if a winner exists, go to WAIT.
  - WAIT: count latency.
  - DONE: issue rvalid; also arbitrate, going to WAIT on a winner, otherwise IDLE.
- Acceptance at edge E: latch winner id, addr, we, wdata; load cnt=MEM_LAT-1; enter WAIT.
- First WAIT cycle (T):
  - mem_en=1.
  - mem_we = latched we.
  - Winner's gnt=1.
- mem_addr/mem_wdata are driven from latched registers throughout WAIT and hold their value otherwise.
- WAIT counter:
  - cnt decrements each WAIT cycle.
  - At the edge where cnt==0, a read captures mem_rdata into the winner's rdata register, then the FSM enters DONE.
- DONE cycle (T+MEM_LAT): winner's rvalid=1.
  - For writes, the rdata register is unchanged.
  - The non-winner's rdata register is never modified.
- Latency: request sampled at E → gnt at T=E+1 → rvalid at E+1+MEM_LAT.
- Throughput: back-to-back, one transaction per MEM_LAT+1 cycles.
- Arbitration when both req are high:
  - DM wins unless streak==MAX_DATA_BURST, in which case IF wins.
  - streak increments (saturating) on a DM grant while if_req=1.
  - streak resets to 0 on any IF grant, or on a DM grant with if_req=0.
- Single requester: that requester wins regardless of streak.
- Requests present during WAIT are not sampled and wait for the next arbitration edge.
- Withdrawing req or changing payload before gnt is a protocol violation: the bench asserts it, the RTL does not handle it.
- busy = (state != IDLE).

Decomposition:
- Package riscv_mem_pkg holds:
  - state encoding (IDLE/WAIT/DONE)
  - requester id constants (REQ_IF=0, REQ_DM=1)
  - MEM_LAT counter width function.
- One sub-module, mem_arb_select: combinational winner pick plus the streak counter register. The FSM, latches and counter stay in the top.

Test Plan:
- Reset values: assert reset mid-simulation → all outputs 0, busy=0 within the same cycle, without waiting for a clock edge.
- Single fetch read, MEM_LAT=2: if_req=1, if_addr=0x100, sampled at E0.
  - Cycle 1: mem_en=1, mem_we=0, mem_addr=0x100, if_gnt=1.
  - mem_rdata=0x00500093 in cycle 2.
  - Cycle 3: if_rvalid=1, if_rdata=0x00500093.
  - dm_* outputs stay 0 throughout.
- Collision: if_req and dm_req (read, 0x200, mem returns 0x0000002A) both rise at E0.
  - DM gnt in cycle 1, dm_rvalid with 0x2A in cycle 3.
  - if_gnt in cycle 4 (arbitrated from DONE), if_rvalid in cycle 6.
- Starvation, MAX_DATA_BURST=4: dm_req and if_req held high continuously.
  - Grant order is DM,DM,DM,DM,IF,DM,…
  - streak is 0 after the IF grant.
- Store: dm_we=1, dm_addr=0x204, dm_wdata=0xDEADBEEF, with dm_rdata previously 0x2A.
  - mem_en=mem_we=1 for exactly one cycle with 0x204/0xDEADBEEF.
  - dm_rvalid pulses once; dm_rdata stays 0x2A.
- Reset in WAIT: assert reset one cycle after if_gnt → no if_rvalid, state IDLE. After deassertion, a fresh fetch to 0x104 completes with standard latency.
